// File: rtl/imem_loader.sv
// Instruction-memory program loader: assembles a big-endian byte stream into
// 32-bit words and writes them to consecutive word addresses starting at 0.
module imem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   nwords,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_wd,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Memory depth as a count; one bit wider than an address so it is representable.
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W:0]   n_q;
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W:0]   word_inc;
  logic [ADDR_W:0]   n_start;
  logic [1:0]        byte_cnt;
  logic [23:0]       shreg;
  logic              accept;
  logic              last_byte;

  assign in_ready  = (state_q == RECV);
  assign accept    = in_valid && in_ready;
  assign last_byte = accept && (byte_cnt == 2'd3);
  assign word_inc  = word_cnt + 1'b1;

  // Requests larger than the memory are clamped so the address never wraps.
  assign n_start = (nwords > DEPTH) ? DEPTH : nwords;

  always_comb begin
    // NOTE: default assigned first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (n_start == '0) ? DONE : RECV;
      RECV:    if (last_byte) state_d = WRITE;
      WRITE:   state_d = (word_inc == n_q) ? DONE : RECV;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      mem_we  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == RECV) || (state_d == WRITE);
      done    <= (state_d == DONE);
      mem_we  <= (state_d == WRITE);
    end
  end

  // Load length and word counter; a fresh start always begins at address 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      n_q      <= '0;
      word_cnt <= '0;
    end else if (state_q == IDLE && start) begin
      n_q      <= n_start;
      word_cnt <= '0;
    end else if (state_q == WRITE) begin
      word_cnt <= word_inc;
    end
  end

  // Byte assembly; byte_cnt clears on reset and on start so no stale bytes survive.
  always_ff @(posedge clk) begin
    if (!reset) begin
      byte_cnt <= '0;
      shreg    <= '0;
    end else if (state_q == IDLE && start) begin
      byte_cnt <= '0;
    end else if (accept) begin
      byte_cnt <= byte_cnt + 2'd1;
      shreg    <= {shreg[15:0], in_data};
    end
  end

  // Write port is loaded together with the move into WRITE and holds otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_a  <= '0;
      mem_wd <= '0;
    end else if (last_byte) begin
      mem_a  <= word_cnt[ADDR_W-1:0];
      mem_wd <= {shreg, in_data};
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven loads, hand sequences for
// reset corners, and randomized loads checked against a stream-level model.
module tb_imem_loader;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int SLEN   = 260;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   nwords;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [31:0]       mem_wd;
  logic              busy;
  logic              done;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .nwords(nwords),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: log every memory write and the handshake/status events.
  typedef struct {
    int          a;
    logic [31:0] wd;
    int          cyc;
  } wr_t;

  wr_t wr_q[$];
  int  cyc      = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;
  int  busy_cyc = 0;
  int  overlap  = 0;
  int  rdy_bad  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset && mem_we) wr_q.push_back('{int'(mem_a), mem_wd, cyc});
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (busy) busy_cyc <= busy_cyc + 1;
    if (busy && done) overlap <= overlap + 1;
    if (in_ready && !busy) rdy_bad <= rdy_bad + 1;
  end

  logic [7:0] stream [0:SLEN-1];

  // One complete load: drive start, feed bytes, then compare against the model:
  // write i lands at address i with bytes 4i..4i+3 big-endian, one cycle after
  // its fourth byte; exactly one done; busy for every cycle from start to done.
  task automatic run_load(input int nw, input int mode, input bit noise,
                          input int expw, input int exp_s2d, input string tag);
    int  s, idx, wbase, dbase, bbase;
    int  fourth[$];
    bit  got_done;
    logic [31:0] exp_wd;
    idx = 0;
    wbase = wr_q.size();
    dbase = done_cnt;
    bbase = busy_cyc;
    nwords = nw[ADDR_W:0];
    start = 1'b1;
    in_valid = 1'b0;
    s = cyc + 1;
    got_done = 1'b0;
    for (int t = 0; t < 4000 && !got_done; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        got_done = 1'b1;
        if (noise) start = 1'b1;
      end else begin
        if (noise && busy && $urandom_range(0, 3) == 0) begin
          start  = 1'b1;
          nwords = (ADDR_W+1)'($urandom_range(0, 127));
        end
        case (mode)
          0:       in_valid = 1'b1;
          1:       in_valid = ~in_valid;
          default: in_valid = 1'($urandom_range(0, 1));
        endcase
        in_data = stream[idx % SLEN];
        if (in_valid && in_ready) begin
          idx++;
          if (idx % 4 == 0) fourth.push_back(cyc + 1);
        end
      end
    end
    check({tag, " done seen"}, 64'(got_done), 64'd1);
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'($urandom);
    end
    in_valid = 1'b0;
    check({tag, " write count"}, 64'(wr_q.size() - wbase), 64'(expw));
    for (int i = 0; i < expw && wbase + i < wr_q.size(); i++) begin
      exp_wd = {stream[4*i], stream[4*i+1], stream[4*i+2], stream[4*i+3]};
      check({tag, " addr"}, 64'(wr_q[wbase+i].a), 64'(i));
      check({tag, " data"}, 64'(wr_q[wbase+i].wd), 64'(exp_wd));
      if (i < fourth.size())
        check({tag, " write latency"}, 64'(wr_q[wbase+i].cyc), 64'(fourth[i]));
    end
    check({tag, " done pulses"}, 64'(done_cnt - dbase), 64'd1);
    if (got_done) begin
      check({tag, " busy cycles"}, 64'(busy_cyc - bbase), 64'(done_cyc - s));
      if (exp_s2d >= 0)
        check({tag, " start to done"}, 64'(done_cyc - s), 64'(exp_s2d));
    end
  endtask

  // Stream kinds: 0 = fixed 8 bytes, 1 = word k is k*0x01010101, 2 = random.
  task automatic fill_stream(input int kind, input logic [63:0] fixed);
    logic [63:0] f;
    f = fixed;
    for (int i = 0; i < SLEN; i++) begin
      case (kind)
        0:       stream[i] = (i < 8) ? f[63-8*i -: 8] : 8'h00;
        1:       stream[i] = 8'(i / 4);
        default: stream[i] = 8'($urandom);
      endcase
    end
  endtask

  typedef struct {
    int          nw;
    int          mode;
    bit          noise;
    int          kind;
    logic [63:0] fixed;
    int          exp_writes;
    int          exp_s2d;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int nw, expw, wbase;

    vecs[0] = '{2,   0, 1'b0, 0, 64'h3C081000_20080005, 2,  10};
    vecs[1] = '{1,   1, 1'b0, 0, 64'hAABBCCDD_00000000, 1,  8};
    vecs[2] = '{0,   0, 1'b0, 2, 64'h0,                 0,  0};
    vecs[3] = '{100, 0, 1'b1, 1, 64'h0,                 64, 320};
    vecs[4] = '{127, 2, 1'b1, 2, 64'h0,                 64, -1};
    vecs[5] = '{64,  0, 1'b0, 2, 64'h0,                 64, 320};

    reset = 1'b0; start = 1'b0; nwords = '0; in_valid = 1'b0; in_data = '0;
    for (int t = 0; t < 2; t++) begin
      start    = 1'($urandom_range(0, 1));
      nwords   = (ADDR_W+1)'($urandom_range(0, 127));
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset mem_we",   64'(mem_we),   64'd0);
    check("reset mem_a",    64'(mem_a),    64'd0);
    check("reset mem_wd",   64'(mem_wd),   64'd0);
    check("reset busy",     64'(busy),     64'd0);
    check("reset done",     64'(done),     64'd0);
    start = 1'b0; in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("idle after reset busy", 64'(busy), 64'd0);

    for (int v = 0; v < 6; v++) begin
      fill_stream(vecs[v].kind, vecs[v].fixed);
      run_load(vecs[v].nw, vecs[v].mode, vecs[v].noise, vecs[v].exp_writes,
               vecs[v].exp_s2d, $sformatf("vec%0d", v));
    end

    // Reset after two bytes of the first word: nothing written, then a clean reload.
    wbase = wr_q.size();
    nwords = 7'd3; start = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 8'hE1;
    @(negedge clk);
    in_data = 8'hE2;
    @(negedge clk);
    reset = 1'b0; in_data = 8'hE3;
    @(negedge clk);
    check("midreset busy",     64'(busy),     64'd0);
    check("midreset in_ready", 64'(in_ready), 64'd0);
    check("midreset mem_we",   64'(mem_we),   64'd0);
    reset = 1'b1; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset no write", 64'(wr_q.size() - wbase), 64'd0);
    fill_stream(0, 64'h11223344_00000000);
    run_load(1, 0, 1'b0, 1, 5, "reload");

    // Randomized loads against the stream model.
    for (int r = 0; r < 5; r++) begin
      nw   = $urandom_range(0, 80);
      expw = (nw > DEPTH) ? DEPTH : nw;
      fill_stream(2, 64'h0);
      run_load(nw, 2, 1'b1, expw, -1, $sformatf("rand%0d_n%0d", r, nw));
    end

    check("busy and done overlap", 64'(overlap), 64'd0);
    check("in_ready outside load", 64'(rdy_bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
